// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RISC-V load/store unit issuing one access at a time to a word-wide, byte-enabled data memory.
// Optional MISALIGN_SPLIT_EN: misaligned accesses become legal; word-crossing ones are split into two bus transactions.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              fault,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FIN   = 3'd3
`ifdef MISALIGN_SPLIT_EN
    ,
    REQ2  = 3'd4,
    WAIT2 = 3'd5
`endif
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              done_q;
  logic              fault_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic              store_q;
`ifdef MISALIGN_SPLIT_EN
  logic [DATA_W-1:0] lo_q;
  logic [3:0]        hi_be_q;
  logic [DATA_W-1:0] hi_wdata_q;
  logic              split_q;
  logic [7:0]        be8;
  logic [63:0]       wd64;
`endif

  logic [1:0]        off;
  logic [3:0]        lane_m;
  logic [DATA_W-1:0] wrep;
  logic              illegal;
  logic              misal;
  logic              bad;
  logic [3:0]        be_lo;
  logic [DATA_W-1:0] wd_lo;

  // Request decode on the raw core inputs; only consumed in IDLE.
  always_comb begin
    off     = addr[1:0];
    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
    misal   = ((funct3[1:0] == 2'b01) && off[0]) ||
              ((funct3[1:0] == 2'b10) && (off != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        lane_m = 4'b0001;
        wrep   = {4{wr_data[7:0]}};
      end
      2'b01: begin
        lane_m = 4'b0011;
        wrep   = {2{wr_data[15:0]}};
      end
      default: begin
        lane_m = 4'b1111;
        wrep   = wr_data;
      end
    endcase
`ifdef MISALIGN_SPLIT_EN
    // Lanes 7:4 of the 8-lane view belong to the following word.
    be8   = {4'b0000, lane_m} << off;
    wd64  = {32'd0, wr_data} << {off, 3'b000};
    be_lo = be8[3:0];
    wd_lo = misal ? wd64[31:0] : wrep;
    bad   = illegal;
`else
    be_lo = lane_m << off;
    wd_lo = wrep;
    bad   = illegal || misal;
`endif
  end

  logic [63:0]       rword;
  logic [31:0]       rsh;
  logic [DATA_W-1:0] ld_ext;

  // Merge (when split), shift the addressed bytes down, then extend.
  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    rword = split_q ? {mem_rdata, lo_q} : {32'd0, mem_rdata};
`else
    rword = {32'd0, mem_rdata};
`endif
    rsh = 32'(rword >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  ld_ext = {{24{rsh[7]}}, rsh[7:0]};
      3'b001:  ld_ext = {{16{rsh[15]}}, rsh[15:0]};
      3'b100:  ld_ext = {24'd0, rsh[7:0]};
      3'b101:  ld_ext = {16'd0, rsh[15:0]};
      default: ld_ext = rsh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rd_data_q   <= '0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      store_q     <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      lo_q        <= '0;
      hi_be_q     <= 4'b0000;
      hi_wdata_q  <= '0;
      split_q     <= 1'b0;
`endif
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            store_q  <= is_store;
            if (bad) begin
              state_q   <= FIN;
              done_q    <= 1'b1;
              fault_q   <= 1'b1;
              rd_data_q <= '0;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
              mem_be_q    <= be_lo;
              mem_wdata_q <= wd_lo;
`ifdef MISALIGN_SPLIT_EN
              split_q    <= |be8[7:4];
              hi_be_q    <= be8[7:4];
              hi_wdata_q <= wd64[63:32];
`endif
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              lo_q        <= mem_rdata;
              state_q     <= REQ2;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= mem_addr_q + ADDR_W'(4);
              mem_be_q    <= hi_be_q;
              mem_wdata_q <= hi_wdata_q;
            end else
`endif
            begin
              state_q   <= FIN;
              done_q    <= 1'b1;
              rd_data_q <= store_q ? '0 : ld_ext;
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        REQ2: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= WAIT2;
          end
        end
        WAIT2: begin
          if (mem_rvalid) begin
            state_q   <= FIN;
            done_q    <= 1'b1;
            rd_data_q <= store_q ? '0 : ld_ext;
          end
        end
`endif
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the core side of the data-memory interface; issues load/store requests to a word-wide, byte-enabled data memory.
- Handles lane steering, byte enables, sign/zero extension per RISC-V funct3, and alignment checks.
- Sits between the EX/MEM stage (single outstanding op) and the data memory port; the memory may insert wait states on both grant and response.

Parameters:
- ADDR_W, 32, byte-address width of core and memory addresses.
- DATA_W, 32, data width; fixed at 32 (four byte lanes).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request strobe; sampled only while req_ready=1.
- req_ready  out  1  high in IDLE only.
- is_store  in  1  1=store, 0=load.
- funct3  in  3  RISC-V width/sign code.
- addr  in  ADDR_W  byte address.
- wr_data  in  32  store data, low-aligned.
- done  out  1  one-cycle completion pulse.
- rd_data  out  32  load result, extended; valid when done=1, held until next done.
- fault  out  1  with done: illegal funct3 or misaligned; no memory access made.
- mem_req  out  1  memory request; held with stable attributes until granted.
- mem_gnt  in  1  grant; address phase completes in the cycle mem_req&mem_gnt.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0).
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-steered store data.
- mem_rvalid  in  1  response strobe; exactly one per grant, >=1 cycle after grant.
- mem_rdata  in  32  read word, valid with mem_rvalid.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; mem_req=0; mem_we=0; mem_be=0; mem_addr=0; mem_wdata=0; done=0; fault=0; rd_data=0.
- Reset mid-transaction abandons the op; mem_req drops immediately. Outstanding responses after reset are ignored.
- FSM states: IDLE, REQ, WAIT, (REQ2, WAIT2 with split), FIN.
- IDLE: on req_valid, latch all inputs and decode.
  - Illegal case (funct3 in {011,110,111}, or a store with funct3 in {100,101}), or misaligned: go to FIN with fault=1.
  - Otherwise go to REQ.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- REQ: mem_req=1; mem_addr = {addr[ADDR_W-1:2],2'b00}. On gnt go to WAIT with mem_req=0; otherwise hold all outputs unchanged.
- WAIT: on mem_rvalid, capture the load lane, then go to FIN. Stores also wait for mem_rvalid as the write acknowledge.
- FIN: done=1 for one cycle; fault is valid; return to IDLE (req_ready=1 the following cycle).
- Min latency: accept at cycle T; mem_req at T+1; gnt at T+1; rvalid at T+2; done at T+3.
- Byte enables:
  - Byte ops: 0001<<addr[1:0].
  - Half ops: 0011<<addr[1:0].
  - Word ops: 1111.
- mem_wdata = wr_data replicated into lanes: byte into all 4 lanes, half into both halves.
- Loads: select bytes at offset addr[1:0].
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: full word.
- rd_data = 0 on fault and on stores.
- mem_rvalid in IDLE/REQ is ignored. mem_gnt without mem_req is ignored.

Optional Feature:
- Macro MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are legal.
  - If the access stays within one word (e.g. LH at offset 1), issue a single access with shifted enables.
  - If it crosses a word boundary, issue two transactions:
    - REQ/WAIT: low word, be = lanes offset..3.
    - REQ2/WAIT2: word at base+4, be = remaining low lanes.
  - Load results are merged before extension. Store data is steered across both words.
  - done fires once, after the second rvalid. fault is reserved for illegal funct3 only.
- Undefined: any misaligned access faults as above; REQ2/WAIT2 are not synthesized.

Test Plan:
- Reset, then LW at 0x100; gnt and rvalid each on the first opportunity; mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; done at T+3; rd_data=0xDEADBEEF; fault=0.
- SB at 0x203, wr_data=0x000000A5 -> mem_we=1, mem_addr=0x200, mem_be=1000, mem_wdata=0xA5A5A5A5; done pulses one cycle after rvalid.
- LB then LBU at 0x302 with mem_rdata=0x0080FF00 -> LB: rd_data=0xFFFFFF80; LBU: rd_data=0x00000080.
- LW at 0x101 (macro off) -> no mem_req; done and fault=1 at T+1; rd_data=0. funct3=011 gives the same response.
- LH at 0x400, gnt withheld 3 cycles, rvalid 2 cycles after gnt -> mem_req and attributes stable throughout; single done; rd_data sign-extended from mem_rdata[15:0]. Assert rst_n=0 during a repeat -> mem_req=0 immediately; req_ready=1 after release.
- Macro on: LW at 0x0FE; low word 0x11223344, high word 0x55667788 -> two requests: 0x0FC be=1100, then 0x100 be=0011; rd_data=0x77881122; one done.
